// File: rtl/psum_pkg.sv
// Shared constants and FSM state type for the partial-sum accumulator.
package psum_pkg;

  localparam int PROD_W_DEF = 11;
  localparam int ACC_W_DEF  = 24;
  localparam int MAX_SHIFT  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } psum_state_e;

endpackage

// File: rtl/psum_term_gen.sv
// Turns one PE product into an ACC_W-wide weighted term: sign-extend, clamp
// the shift to MAX_SHIFT, shift left, and flag terms that do not fit ACC_W.
module psum_term_gen
  import psum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [PROD_W-1:0] prod_i,
  input  logic [3:0]        shift_i,
  output logic [ACC_W-1:0]  term_o,
  output logic              ovf_o
);

  // Wide enough to hold any product shifted by MAX_SHIFT without loss.
  localparam int EXT_W = ACC_W + MAX_SHIFT;

  logic [3:0]           sh;
  logic [EXT_W-1:0]     ext;
  logic [EXT_W-1:0]     wide;
  logic [EXT_W-ACC_W:0] top_bits;

  always_comb begin
    sh       = (shift_i > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : shift_i;
    ext      = {{(EXT_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    wide     = ext << sh;
    // The term fits only if everything above ACC_W-1 repeats the sign bit.
    top_bits = wide[EXT_W-1:ACC_W-1];
    term_o   = wide[ACC_W-1:0];
    ovf_o    = (top_bits != '0) && (top_bits != '1);
  end

endmodule

// File: rtl/psum_accumulator.sv
// Groups weighted PE products into one signed sum with beat count and sticky
// overflow. Define PSUM_SAT_EN to clamp on overflow instead of wrapping.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PROD_W-1:0] i_prod,
  input  logic [3:0]        i_shift,
  input  logic              i_first,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf,
  output logic [7:0]        o_beat_cnt,
  output psum_state_e       o_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and o_ready depends only on state.

`ifdef PSUM_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  psum_state_e      state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q;

  logic [ACC_W-1:0] term;
  logic             term_ovf;
  logic [ACC_W:0]   sum_ext;
  logic             add_ovf;
  logic             accept;
  logic             load;

  psum_term_gen #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_term_gen (
    .prod_i  (i_prod),
    .shift_i (i_shift),
    .term_o  (term),
    .ovf_o   (term_ovf)
  );

  assign o_ready = (state_q != ST_HOLD);
  assign accept  = i_valid && o_ready;
  // A beat in IDLE always opens a fresh group, even without i_first.
  assign load    = accept && (i_first || (state_q == ST_IDLE));

  always_comb begin
    sum_ext = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
    add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (load) begin
      acc_d = term;
      ovf_d = term_ovf;
      cnt_d = 8'd1;
`ifdef PSUM_SAT_EN
      if (term_ovf) acc_d = i_prod[PROD_W-1] ? SAT_MIN : SAT_MAX;
`endif
    end else if (accept) begin
      acc_d = sum_ext[ACC_W-1:0];
      ovf_d = ovf_q | term_ovf | add_ovf;
      cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
`ifdef PSUM_SAT_EN
      // Once clamped, the accumulator stays put for the rest of the group.
      if (ovf_q)         acc_d = acc_q;
      else if (term_ovf) acc_d = i_prod[PROD_W-1] ? SAT_MIN : SAT_MAX;
      else if (add_ovf)  acc_d = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            state_q <= i_last ? ST_HOLD : ST_ACCUM;
            valid_q <= i_last;
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_sum      = acc_q;
  assign o_ovf      = ovf_q;
  assign o_beat_cnt = cnt_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized and directed bench for psum_accumulator against an integer model
// of the group arithmetic (wrap or clamp chosen by PSUM_SAT_EN).
module tb_psum_accumulator;
  import psum_pkg::*;

  localparam int PROD_W = 11;
  localparam int ACC_W  = 24;
  localparam longint LIM = longint'(1) << (ACC_W - 1);

  logic              clk;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [PROD_W-1:0] i_prod;
  logic [3:0]        i_shift;
  logic              i_first;
  logic              i_last;
  logic              o_valid;
  logic              i_ready;
  logic [ACC_W-1:0]  o_sum;
  logic              o_ovf;
  logic [7:0]        o_beat_cnt;
  psum_state_e       o_state;

  int errors = 0;
  int checks = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];
  logic [7:0]       exp_cnt_q[$];
  logic [ACC_W-1:0] e_sum;
  logic             e_ovf;
  logic [7:0]       e_cnt;

  longint m_acc;
  bit     m_ovf;
  int     m_cnt;
  bit     m_busy;

  psum_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_prod     (i_prod),
    .i_shift    (i_shift),
    .i_first    (i_first),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sum      (o_sum),
    .o_ovf      (o_ovf),
    .o_beat_cnt (o_beat_cnt),
    .o_state    (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint wrap(input longint x);
    longint m;
    longint r;
    m = longint'(1) << ACC_W;
    r = x % m;
    if (r < 0) r += m;
    if (r >= LIM) r -= m;
    return r;
  endfunction

  function automatic longint clamp(input longint x);
    return (x >= LIM) ? LIM - 1 : -LIM;
  endfunction

  task automatic model_accept(input int prod, input int sh, input bit f, input bit l);
    longint t;
    longint s;
    bit     t_ovf;
    bit     a_ovf;
    t     = longint'(prod) * (longint'(1) << ((sh > 12) ? 12 : sh));
    t_ovf = (t >= LIM) || (t < -LIM);
    if (f || !m_busy) begin
      m_cnt = 1;
      m_ovf = t_ovf;
`ifdef PSUM_SAT_EN
      m_acc = t_ovf ? clamp(t) : t;
`else
      m_acc = wrap(t);
`endif
    end else begin
      s     = m_acc + wrap(t);
      a_ovf = (s >= LIM) || (s < -LIM);
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
`ifdef PSUM_SAT_EN
      if (!m_ovf) m_acc = t_ovf ? clamp(t) : (a_ovf ? clamp(s) : s);
`else
      m_acc = wrap(s);
`endif
      m_ovf = m_ovf | t_ovf | a_ovf;
    end
    m_busy = !l;
    if (l) begin
      exp_q.push_back(ACC_W'(m_acc));
      exp_ovf_q.push_back(m_ovf);
      exp_cnt_q.push_back(8'(m_cnt));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input int prod, input int sh, input bit f, input bit l);
    int n;
    n       = 0;
    i_valid = 1'b1;
    i_prod  = PROD_W'(prod);
    i_shift = 4'(sh);
    i_first = f;
    i_last  = l;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: o_ready=%0b required 1", o_ready);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(prod, sh, f, l);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic pop_expected();
    e_sum = exp_q.pop_front();
    e_ovf = exp_ovf_q.pop_front();
    e_cnt = exp_cnt_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_prod = '0; i_shift = '0; i_first = 1'b0; i_last = 1'b0;
    m_busy = 1'b0; m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
    repeat (3) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: o_valid=%0b required 0", o_valid); end
    checks++; if (o_sum !== '0) begin errors++; $display("FAIL reset_sum: o_sum=%0d required 0", o_sum); end
    checks++; if (o_ovf !== 1'b0 || o_beat_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf_cnt: ovf=%0b cnt=%0d required 0 0", o_ovf, o_beat_cnt); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: o_ready=%0b required 1", o_ready); end
    i_rst = 1'b0;
  endtask

  task automatic test_single_beat();
    send_beat(-5, 0, 1'b1, 1'b1);
    pop_expected();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: o_valid=%0b required 1", o_valid); end
    checks++; if (o_sum !== ACC_W'(-5) || o_sum !== e_sum) begin errors++; $display("FAIL single_sum: o_sum=%0d required %0d", $signed(o_sum), $signed(e_sum)); end
    checks++; if (o_beat_cnt !== 8'd1 || o_ovf !== 1'b0) begin errors++; $display("FAIL single_cnt_ovf: cnt=%0d ovf=%0b required 1 0", o_beat_cnt, o_ovf); end
    release_result();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: o_valid=%0b required 0", o_valid); end
  endtask

  task automatic test_weighted();
    send_beat(3, 0, 1'b1, 1'b0);
    send_beat(-2, 2, 1'b0, 1'b0);
    send_beat(7, 4, 1'b0, 1'b0);
    send_beat(1, 6, 1'b0, 1'b1);
    pop_expected();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL weighted_valid: o_valid=%0b required 1", o_valid); end
    checks++; if (o_sum !== ACC_W'(171) || o_sum !== e_sum) begin errors++; $display("FAIL weighted_sum: o_sum=%0d required %0d", $signed(o_sum), $signed(e_sum)); end
    checks++; if (o_beat_cnt !== 8'd4 || o_ovf !== e_ovf) begin errors++; $display("FAIL weighted_cnt_ovf: cnt=%0d ovf=%0b required 4 %0b", o_beat_cnt, o_ovf, e_ovf); end
    release_result();
  endtask

  task automatic test_hold_backpressure();
    logic [ACC_W-1:0] held;
    send_beat(-77, 3, 1'b1, 1'b1);
    pop_expected();
    held = o_sum;
    checks++; if (o_sum !== e_sum) begin errors++; $display("FAIL hold_sum: o_sum=%0d required %0d", $signed(o_sum), $signed(e_sum)); end
    i_valid = 1'b1; i_prod = PROD_W'(9); i_shift = 4'd1; i_first = 1'b0; i_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL hold_ready: o_ready=%0b o_valid=%0b required 0 1", o_ready, o_valid); end
      checks++; if (o_sum !== held || o_beat_cnt !== 8'd1) begin errors++; $display("FAIL hold_stable: o_sum=%0d cnt=%0d required %0d 1", $signed(o_sum), o_beat_cnt, $signed(held)); end
    end
    release_result();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL hold_release: o_valid=%0b o_ready=%0b required 0 1", o_valid, o_ready); end
    // The beat still held on the inputs is taken now, as a fresh group.
    @(posedge clk);
    model_accept(9, 1, 1'b0, 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
    pop_expected();
    checks++; if (o_valid !== 1'b1 || o_sum !== e_sum || o_sum !== ACC_W'(18)) begin errors++; $display("FAIL hold_new_group: o_valid=%0b o_sum=%0d required 1 %0d", o_valid, $signed(o_sum), $signed(e_sum)); end
    checks++; if (o_beat_cnt !== 8'd1) begin errors++; $display("FAIL hold_new_cnt: cnt=%0d required 1", o_beat_cnt); end
    release_result();
  endtask

  task automatic test_overflow();
    int ovf_sum;
`ifdef PSUM_SAT_EN
    ovf_sum = 8388607;
`else
    ovf_sum = -4206592;
`endif
    send_beat(1023, 12, 1'b1, 1'b0);
    send_beat(1023, 12, 1'b0, 1'b0);
    send_beat(1023, 12, 1'b0, 1'b1);
    pop_expected();
    checks++; if (o_ovf !== 1'b1 || o_ovf !== e_ovf) begin errors++; $display("FAIL ovf_flag: o_ovf=%0b required 1", o_ovf); end
    checks++; if (o_sum !== ACC_W'(ovf_sum) || o_sum !== e_sum) begin errors++; $display("FAIL ovf_sum: o_sum=%0d required %0d", $signed(o_sum), ovf_sum); end
    release_result();
    // Shift codes above 12 behave as 12; a single beat then fits without overflow.
    send_beat(-1024, 15, 1'b1, 1'b1);
    pop_expected();
    checks++; if (o_sum !== ACC_W'(-4194304) || o_ovf !== 1'b0) begin errors++; $display("FAIL shift_clamp: o_sum=%0d ovf=%0b required -4194304 0", $signed(o_sum), o_ovf); end
    release_result();
  endtask

  task automatic test_reset_mid_group();
    send_beat(100, 2, 1'b1, 1'b0);
    send_beat(50, 1, 1'b0, 1'b0);
    i_rst = 1'b1;
    @(posedge clk);
    m_busy = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    checks++; if (o_sum !== '0 || o_ovf !== 1'b0 || o_beat_cnt !== 8'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: sum=%0d ovf=%0b cnt=%0d valid=%0b required all 0", $signed(o_sum), o_ovf, o_beat_cnt, o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: o_ready=%0b required 1", o_ready); end
    send_beat(4, 0, 1'b0, 1'b1);
    pop_expected();
    checks++; if (o_sum !== ACC_W'(4) || o_sum !== e_sum || o_beat_cnt !== 8'd1) begin errors++; $display("FAIL rst_mid_after: o_sum=%0d cnt=%0d required 4 1", $signed(o_sum), o_beat_cnt); end
    release_result();
  endtask

  task automatic test_restart();
    send_beat(5, 0, 1'b1, 1'b0);
    send_beat(6, 0, 1'b0, 1'b0);
    send_beat(2, 0, 1'b1, 1'b1);
    pop_expected();
    checks++; if (o_sum !== ACC_W'(2) || o_sum !== e_sum) begin errors++; $display("FAIL restart_sum: o_sum=%0d required 2", $signed(o_sum)); end
    checks++; if (o_beat_cnt !== 8'd1) begin errors++; $display("FAIL restart_cnt: cnt=%0d required 1", o_beat_cnt); end
    release_result();
  endtask

  task automatic test_cnt_saturate();
    for (int b = 0; b < 300; b++) send_beat(1, 0, b == 0, b == 299);
    pop_expected();
    checks++; if (o_beat_cnt !== 8'd255 || o_beat_cnt !== e_cnt) begin errors++; $display("FAIL cnt_saturate: cnt=%0d required 255", o_beat_cnt); end
    checks++; if (o_sum !== ACC_W'(300)) begin errors++; $display("FAIL cnt_sum: o_sum=%0d required 300", $signed(o_sum)); end
    release_result();
  endtask

  task automatic test_random();
    int len;
    int gap;
    int hold;
    logic [ACC_W-1:0] held;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        gap = $urandom_range(0, 2);
        // Junk on the data inputs while i_valid is low must be ignored.
        for (int k = 0; k < gap; k++) begin
          i_valid = 1'b0; i_prod = PROD_W'($urandom); i_shift = 4'($urandom);
          i_first = 1'($urandom); i_last = 1'($urandom);
          @(negedge clk);
        end
        send_beat(int'($signed(PROD_W'($urandom))), $urandom_range(0, 15),
                  (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0),
                  b == len - 1);
      end
      pop_expected();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rand_valid g%0d: o_valid=%0b required 1", g, o_valid); end
      checks++; if (o_sum !== e_sum || o_ovf !== e_ovf || o_beat_cnt !== e_cnt) begin errors++; $display("FAIL rand_result g%0d: sum=%0d ovf=%0b cnt=%0d required %0d %0b %0d", g, $signed(o_sum), o_ovf, o_beat_cnt, $signed(e_sum), e_ovf, e_cnt); end
      held = o_sum;
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) @(negedge clk);
      checks++; if (o_sum !== held || o_valid !== 1'b1) begin errors++; $display("FAIL rand_hold g%0d: sum=%0d valid=%0b required %0d 1", g, $signed(o_sum), o_valid, $signed(held)); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_weighted();
    test_hold_backpressure();
    test_overflow();
    test_reset_mid_group();
    test_restart();
    test_cnt_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
